// File: rtl/sevenseg_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : sevenseg_scanner
//  Description : Time-multiplexed eight-digit seven-segment driver. Digit codes
//                and decimal points are snapshotted once per frame, each slot
//                starts with an anode blanking window, and all outputs are
//                registered (one cycle behind the scan counter).
//                Optional brightness control is compiled in with the macro
//                SEVENSEG_DIM_EN (adds the 2-bit dim port).
//  Revision    : 1.0 - initial release
// ============================================================================
module sevenseg_scanner #(
    parameter int SLOT_CYCLES  = 100000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] d0,
    input  logic [6:0] d1,
    input  logic [6:0] d2,
    input  logic [6:0] d3,
    input  logic [6:0] d4,
    input  logic [6:0] d5,
    input  logic [6:0] d6,
    input  logic [6:0] d7,
    input  logic [7:0] dp_mask,
`ifdef SEVENSEG_DIM_EN
    input  logic [1:0] dim,
`endif
    output logic [6:0] segs_n,
    output logic       dp_n,
    output logic [7:0] an_n,
    output logic       frame_start
);

    localparam int                CNT_W      = $clog2(SLOT_CYCLES);
    localparam logic [CNT_W-1:0]  C_CNT_LAST = CNT_W'(SLOT_CYCLES - 1);
    localparam logic [31:0]       C_BLANK32  = 32'(BLANK_CYCLES);
`ifdef SEVENSEG_DIM_EN
    localparam logic [31:0]       C_SLOT32   = 32'(SLOT_CYCLES);
    localparam logic [31:0]       C_STEP32   = 32'((SLOT_CYCLES - BLANK_CYCLES) >> 2);
`endif

    // Scan position
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       digit_q, digit_d;

    // Frame snapshot of the inputs
    logic [7:0][6:0]  shadow_q, shadow_d;
    logic [7:0]       sdp_q, sdp_d;
`ifdef SEVENSEG_DIM_EN
    logic [1:0]       dim_q, dim_d;
    logic [31:0]      w_lim;
`endif

    // Registered outputs
    logic [6:0]       segs_q, segs_d;
    logic             dp_q, dp_d;
    logic [7:0]       an_q, an_d;
    logic             fs_q;

    logic             w_snap;
    logic [6:0]       w_code;
    logic             w_an_on;
    logic [31:0]      w_cnt32;

    // Segment pattern for one digit code, {g,f,e,d,c,b,a} active low
    function automatic logic [6:0] decode(input logic [6:0] c);
        logic [6:0] s;
        if (c[6]) begin
            s = 7'h7F;
        end else if (c[5:4] != 2'b00) begin
            s = 7'b0111111;
        end else begin
            case (c[3:0])
                4'h0:    s = 7'b1000000;
                4'h1:    s = 7'b1111001;
                4'h2:    s = 7'b0100100;
                4'h3:    s = 7'b0110000;
                4'h4:    s = 7'b0011001;
                4'h5:    s = 7'b0010010;
                4'h6:    s = 7'b0000010;
                4'h7:    s = 7'b1111000;
                4'h8:    s = 7'b0000000;
                4'h9:    s = 7'b0010000;
                4'hA:    s = 7'b0001000;
                4'hB:    s = 7'b0000011;
                4'hC:    s = 7'b1000110;
                4'hD:    s = 7'b0100001;
                4'hE:    s = 7'b0000110;
                default: s = 7'b0001110;
            endcase
        end
        return s;
    endfunction

    // Scan counter advance and snapshot capture
    always_comb begin
        w_snap  = (cnt_q == '0) && (digit_q == 3'd0);
        cnt_d   = cnt_q + CNT_W'(1);
        digit_d = digit_q;
        if (cnt_q == C_CNT_LAST) begin
            cnt_d   = '0;
            digit_d = digit_q + 3'd1;
        end
        shadow_d = shadow_q;
        sdp_d    = sdp_q;
`ifdef SEVENSEG_DIM_EN
        dim_d    = dim_q;
`endif
        if (w_snap) begin
            shadow_d = {d7, d6, d5, d4, d3, d2, d1, d0};
            sdp_d    = dp_mask;
`ifdef SEVENSEG_DIM_EN
            dim_d    = dim;
`endif
        end
    end

    // Output pattern for the current slot; the freshly captured snapshot is
    // used on the capture edge so slot 0 never shows the previous frame.
    always_comb begin
        w_code  = shadow_d[digit_q];
        w_cnt32 = 32'(cnt_q);
        w_an_on = (w_cnt32 >= C_BLANK32) && !w_code[6];
`ifdef SEVENSEG_DIM_EN
        if (dim_d == 2'd3) begin
            w_lim = C_SLOT32;
        end else begin
            w_lim = C_BLANK32 + C_STEP32 * (32'(dim_d) + 32'd1);
        end
        w_an_on = w_an_on && (w_cnt32 < w_lim);
`endif
        segs_d = decode(w_code);
        dp_d   = ~sdp_d[digit_q];
        an_d   = w_an_on ? ~(8'b1 << digit_q) : 8'hFF;
    end

    // State and output registers with immediate reset to the blank display
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= '0;
            digit_q  <= 3'd0;
            shadow_q <= {8{7'h7F}};
            sdp_q    <= 8'h00;
`ifdef SEVENSEG_DIM_EN
            dim_q    <= 2'd0;
`endif
            segs_q   <= 7'h7F;
            dp_q     <= 1'b1;
            an_q     <= 8'hFF;
            fs_q     <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            digit_q  <= digit_d;
            shadow_q <= shadow_d;
            sdp_q    <= sdp_d;
`ifdef SEVENSEG_DIM_EN
            dim_q    <= dim_d;
`endif
            segs_q   <= segs_d;
            dp_q     <= dp_d;
            an_q     <= an_d;
            fs_q     <= w_snap;
        end
    end

    assign segs_n      = segs_q;
    assign dp_n        = dp_q;
    assign an_n        = an_q;
    assign frame_start = fs_q;

endmodule
`default_nettype wire

// File: tb/tb_sevenseg_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sevenseg_scanner
//  Description : Self-checking bench for sevenseg_scanner with an 8-cycle slot
//                and 2-cycle blanking (64-cycle frame). Expected outputs come
//                from a behavioural scan model through a scoreboard queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sevenseg_scanner;

    localparam int SLOT  = 8;
    localparam int BLANK = 2;
`ifdef SEVENSEG_DIM_EN
    localparam int STEP  = (SLOT - BLANK) >> 2;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] d [8];
    logic [7:0] dp_mask = 8'h00;
    logic [6:0] segs_n;
    logic       dp_n;
    logic [7:0] an_n;
    logic       frame_start;
`ifdef SEVENSEG_DIM_EN
    logic [1:0] dim_drv = 2'd3;
    int         m_dim;
`endif

    typedef struct packed {
        logic [6:0] segs;
        logic       dp;
        logic [7:0] an;
        logic       fs;
    } exp_t;

    exp_t       q[$];
    int         n_pass  = 0;
    int         n_total = 0;

    // Reference scan state
    int         m_cnt;
    int         m_digit;
    logic [6:0] m_sh [8];
    logic [7:0] m_dp;

    logic [6:0] hex_tbl [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    sevenseg_scanner #(
        .SLOT_CYCLES (SLOT),
        .BLANK_CYCLES(BLANK)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .d0         (d[0]),
        .d1         (d[1]),
        .d2         (d[2]),
        .d3         (d[3]),
        .d4         (d[4]),
        .d5         (d[5]),
        .d6         (d[6]),
        .d7         (d[7]),
        .dp_mask    (dp_mask),
`ifdef SEVENSEG_DIM_EN
        .dim        (dim_drv),
`endif
        .segs_n     (segs_n),
        .dp_n       (dp_n),
        .an_n       (an_n),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] exp_seg(input logic [6:0] c);
        if (c[6])                return 7'h7F;
        else if (c[5:4] != 2'b0) return 7'b0111111;
        else                     return hex_tbl[c[3:0]];
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        n_total++;
        assert (obs === expv) begin
            n_pass++;
        end else begin
            $error("FAIL %s observed=%h expected=%h (t=%0t)", tag, obs, expv, $time);
        end
    endtask

    task automatic model_reset();
        m_cnt   = 0;
        m_digit = 0;
        m_dp    = 8'h00;
        for (int i = 0; i < 8; i++) m_sh[i] = 7'h7F;
`ifdef SEVENSEG_DIM_EN
        m_dim   = 0;
`endif
    endtask

    // One clock: predict, push, clock, pop, compare
    task automatic step();
        exp_t       e;
        logic [6:0] c;
        logic       on;
        int         k;
        e.fs = (m_cnt == 0) && (m_digit == 0);
        if (e.fs) begin
            for (int i = 0; i < 8; i++) m_sh[i] = d[i];
            m_dp = dp_mask;
`ifdef SEVENSEG_DIM_EN
            m_dim = int'(dim_drv);
`endif
        end
        k      = m_digit;
        c      = m_sh[k];
        e.segs = exp_seg(c);
        e.dp   = ~m_dp[k];
        on     = (m_cnt >= BLANK) && !c[6];
`ifdef SEVENSEG_DIM_EN
        on     = on && ((m_dim == 3) || (m_cnt < BLANK + STEP * (m_dim + 1)));
`endif
        e.an   = on ? ~(8'h01 << k) : 8'hFF;
        q.push_back(e);
        m_cnt++;
        if (m_cnt == SLOT) begin
            m_cnt   = 0;
            m_digit = (m_digit + 1) % 8;
        end
        @(posedge clk);
        #1;
        e = q.pop_front();
        chk("segs_n", {1'b0, segs_n}, {1'b0, e.segs});
        chk("dp_n", {7'b0, dp_n}, {7'b0, e.dp});
        chk("an_n", an_n, e.an);
        chk("frame_start", {7'b0, frame_start}, {7'b0, e.fs});
        chk("an_onehot", {7'b0, ($countones(~an_n) <= 1)}, 8'h01);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_segs"}, {1'b0, segs_n}, 8'h7F);
        chk({tag, "_dp"}, {7'b0, dp_n}, 8'h01);
        chk({tag, "_an"}, an_n, 8'hFF);
        chk({tag, "_fs"}, {7'b0, frame_start}, 8'h00);
    endtask

    initial begin
        // Reset held: blank display
        d[0] = 7'h05;
        for (int i = 1; i < 8; i++) d[i] = 7'h7F;
        model_reset();
        repeat (3) begin
            @(posedge clk);
            #1;
            chk_reset_outputs("reset_hold");
        end
        rst = 1'b0;

        // Frame A: single digit 5 in slot 0, all others blank
        run(64);

        // Frame B: digits 7..0
        for (int i = 0; i < 8; i++) d[i] = 7'(i);
`ifdef SEVENSEG_DIM_EN
        dim_drv = 2'd0;
`endif
        run(64);

        // Frame C: digits F..8 with mixed decimal points
        for (int i = 0; i < 8; i++) d[i] = 7'(i + 8);
        dp_mask = 8'h5A;
`ifdef SEVENSEG_DIM_EN
        dim_drv = 2'd1;
`endif
        run(64);

        // Frame D: dash on digit 0, only decimal point on digit 7
        d[0] = 7'h10;
        d[1] = 7'h25;
        d[2] = 7'h7F;
        d[7] = 7'h00;
        dp_mask = 8'h80;
`ifdef SEVENSEG_DIM_EN
        dim_drv = 2'd2;
`endif
        run(64);

        // Frame E: d0 changes mid-frame and must not show until the next frame
        d[0] = 7'h03;
        dp_mask = 8'h00;
`ifdef SEVENSEG_DIM_EN
        dim_drv = 2'd3;
`endif
        run(27);
        d[0] = 7'h09;
        run(37);

        // Frame F: new value now visible; then stop partway into slot 5
        run(64);
        run(43);

        // Asynchronous reset between clock edges
        #2;
        rst = 1'b1;
        #1;
        chk_reset_outputs("async_reset");
        q.delete();
        model_reset();
        @(posedge clk);
        #1;
        chk_reset_outputs("reset_after_edge");
        rst = 1'b0;

        // Scanning restarts at slot 0 with a fresh snapshot
        run(20);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Absolute time limit so the run always terminates
    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "time limit reached");
    end

endmodule
`default_nettype wire
